// File: rtl/delay_pkg.sv
// Shared definitions for the delay-line family (echo now; chorus and phaser later).
package delay_pkg;

    localparam int SAMPLE_W_DEF = 12;
    localparam int ADDR_W_DEF   = 14;
    localparam int MS_SHIFT_DEF = 3;
    localparam int DEL_MS_W     = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        READ = 2'd2,
        MIX  = 2'd3
    } state_t;

    // Convert a millisecond delay to a sample count and clamp it to the deepest
    // reachable tap (DEPTH-1). The shift is done at 32 bits so nothing is lost
    // before the clamp.
    function automatic logic [31:0] ms_to_samples(input logic [DEL_MS_W-1:0] ms,
                                                  input int                  ms_shift,
                                                  input int                  addr_w);
        logic [31:0] wide;
        logic [31:0] max_s;
        wide  = {{(32-DEL_MS_W){1'b0}}, ms} << ms_shift;
        max_s = (32'd1 << addr_w) - 32'd1;
        return (wide > max_s) ? max_s : wide;
    endfunction

endpackage

// File: rtl/echo_delay_line_if.sv
// Sample-stream handshake between the ADC path / settings decoder and the echo block.
interface echo_delay_line_if
    import delay_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF
);
    logic [DEL_MS_W-1:0]        del_ms;
    logic                       in_valid;
    logic signed [SAMPLE_W-1:0] in_sample;
    logic                       in_ready;
    logic                       out_valid;
    logic signed [SAMPLE_W-1:0] out_sample;
    logic                       overrun;

    modport master (
        output del_ms, in_valid, in_sample,
        input  in_ready, out_valid, out_sample, overrun
    );

    modport slave (
        input  del_ms, in_valid, in_sample,
        output in_ready, out_valid, out_sample, overrun
    );
endinterface

// File: rtl/sample_ram.sv
// Simple dual-port sample memory: one write port, one registered read port.
// No reset on the array or read register so the tools can map it to block RAM.
module sample_ram #(
    parameter int SAMPLE_W = 12,
    parameter int ADDR_W   = 14
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [SAMPLE_W-1:0] wdata,
    input  logic                re,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [SAMPLE_W-1:0] rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [SAMPLE_W-1:0] rdata_q;

    // Write port and one-cycle-latency read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/echo_delay_line.sv
// Echo delay line: stores each accepted sample in a circular buffer and mixes
// it 50/50 with the sample written del_ms milliseconds earlier.
module echo_delay_line
    import delay_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int MS_SHIFT = MS_SHIFT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    echo_delay_line_if.slave  bus
);
    localparam logic [ADDR_W-1:0] FILL_MAX = '1;

    state_t                     state_q, state_d;
    logic signed [SAMPLE_W-1:0] in_q, in_d;
    logic signed [SAMPLE_W-1:0] delayed_q, delayed_d;
    logic signed [SAMPLE_W-1:0] out_q, out_d;
    logic [ADDR_W-1:0]          del_s_q, del_s_d;
    logic [ADDR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]          fill_q, fill_d;
    logic                       out_valid_q, out_valid_d;
    logic                       overrun_q, overrun_d;

    logic                       ram_we;
    logic                       ram_re;
    logic [ADDR_W-1:0]          rd_addr;
    logic [SAMPLE_W-1:0]        ram_rdata;
    logic signed [SAMPLE_W:0]   mix_sum;

    sample_ram #(
        .SAMPLE_W (SAMPLE_W),
        .ADDR_W   (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (in_q),
        .re    (ram_re),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // Next-state, datapath and RAM control for the accept/calc/read/mix sequence.
    always_comb begin
        state_d     = state_q;
        in_d        = in_q;
        delayed_d   = delayed_q;
        out_d       = out_q;
        del_s_d     = del_s_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        out_valid_d = 1'b0;
        overrun_d   = 1'b0;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        // Address arithmetic wraps naturally at ADDR_W bits.
        rd_addr     = wr_ptr_q - del_s_q;
        // One extra bit keeps the sum exact; dropping the LSB is a floor divide by 2.
        mix_sum     = {in_q[SAMPLE_W-1], in_q} + {delayed_q[SAMPLE_W-1], delayed_q};

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    in_d    = bus.in_sample;
                    del_s_d = ADDR_W'(ms_to_samples(bus.del_ms, MS_SHIFT, ADDR_W));
                    state_d = CALC;
                end
            end
            CALC: begin
                ram_re  = 1'b1;
                state_d = READ;
            end
            READ: begin
                // Until enough samples have been written the tap points at stale
                // RAM, so substitute silence during warm-up.
                if ((del_s_q != '0) && (fill_q >= del_s_q)) begin
                    delayed_d = ram_rdata;
                end else begin
                    delayed_d = '0;
                end
                state_d = MIX;
            end
            MIX: begin
                ram_we      = 1'b1;
                wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
                fill_d      = (fill_q == FILL_MAX) ? fill_q : fill_q + ADDR_W'(1);
                out_d       = (del_s_q == '0) ? in_q : mix_sum[SAMPLE_W:1];
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A strobe outside IDLE is dropped; only the pulse records it.
        if (bus.in_valid && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // State and datapath registers; reset discards any in-flight sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_q        <= '0;
            delayed_q   <= '0;
            out_q       <= '0;
            del_s_q     <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_q        <= in_d;
            delayed_q   <= delayed_d;
            out_q       <= out_d;
            del_s_q     <= del_s_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_sample = out_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_echo_delay_line.sv
// Bench for echo_delay_line: directed vector table, hand-written corner
// sequences and a long randomized run checked against a sample-history model.
module tb_echo_delay_line;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    echo_delay_line_if bus ();

    echo_delay_line dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Every sample accepted since the last reset, oldest first.
    int hist[$];

    typedef struct {
        bit rst;
        int sample;
        int del_ms;
        int expv;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int rnd_s();
        return int'($urandom_range(4095)) - 2048;
    endfunction

    // Expected output from the rules: delay in samples is ms*8 capped at 16383;
    // zero delay passes the input through; otherwise average with the sample
    // that many positions back in history, or with 0 if history is too short.
    function automatic int model_out(input int s, input int ms);
        int ds;
        int n;
        int d;
        ds = ms * 8;
        if (ds > 16383) ds = 16383;
        n = hist.size();
        if (ds == 0) return s;
        d = (n >= ds) ? hist[n - ds] : 0;
        return (s + d) >>> 1;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, " in_ready"},   int'(bus.in_ready),   1);
        check({tag, " out_valid"},  int'(bus.out_valid),  0);
        check({tag, " out_sample"}, int'($signed(bus.out_sample)), 0);
        check({tag, " overrun"},    int'(bus.overrun),    0);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        hist.delete();
    endtask

    // One accepted sample, called at a negedge with the block idle. ms_mid is
    // placed on del_ms while the FSM is in READ.
    task automatic xfer(input int s, input int ms, input int ms_mid,
                        input int expv, input string tag);
        int got;
        check({tag, " ready"}, int'(bus.in_ready), 1);
        bus.in_valid  = 1'b1;
        bus.in_sample = s[11:0];
        bus.del_ms    = ms[11:0];
        @(negedge clk);                         // accepted, CALC
        bus.in_valid = 1'b0;
        check({tag, " busy"}, int'(bus.in_ready), 0);
        @(negedge clk);                         // READ
        bus.del_ms = ms_mid[11:0];
        @(negedge clk);                         // MIX
        check({tag, " early_valid"}, int'(bus.out_valid), 0);
        @(negedge clk);                         // back in IDLE, result out
        check({tag, " out_valid"}, int'(bus.out_valid), 1);
        got = int'($signed(bus.out_sample));
        check({tag, " out_sample"}, got, expv);
        hist.push_back(s);
        txn++;
        $display("txn %0d %s in=%0d del_ms=%0d out=%0d exp=%0d", txn, tag, s, ms, got, expv);
    endtask

    task automatic xfer_model(input int s, input int ms, input string tag);
        xfer(s, ms, ms, model_out(s, ms), tag);
    endtask

    initial begin
        int sseq[11] = '{-2048, 2047, 0, 0, 0, 0, 0, 0, -2048, 2047, -1};
        int sexp[11] = '{-1024, 1023, 0, 0, 0, 0, 0, 0, -2048, 2047, -1};
        int msset[7] = '{0, 1, 2, 3, 100, 1500, 4095};
        int a;
        int b;
        int exp_a;
        int s;

        // Directed table: bypass, echo warm-up, signed extremes.
        vecs.push_back('{1'b1, 100, 0, 100});
        vecs.push_back('{1'b0, -37, 0, -37});
        for (int k = 1; k <= 20; k++) begin
            vecs.push_back('{(k == 1), k * 10, 1, (k <= 8) ? k * 5 : 10 * k - 40});
        end
        for (int i = 0; i < 11; i++) begin
            vecs.push_back('{(i == 0), sseq[i], 1, sexp[i]});
        end

        bus.in_valid  = 1'b0;
        bus.in_sample = '0;
        bus.del_ms    = '0;
        rst_n         = 1'b0;

        // Reset values, during and after reset.
        repeat (3) @(negedge clk);
        check_idle_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_reset");

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            xfer(vecs[i].sample, vecs[i].del_ms, vecs[i].del_ms, vecs[i].expv, "vec");
        end

        // Overrun: strobe on two consecutive cycles, the second is dropped.
        a = rnd_s();
        b = rnd_s();
        exp_a = model_out(a, 1);
        bus.in_valid  = 1'b1;
        bus.in_sample = a[11:0];
        bus.del_ms    = 12'd1;
        @(negedge clk);
        check("ovr_first", int'(bus.overrun), 0);
        bus.in_sample = b[11:0];
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("ovr_pulse", int'(bus.overrun), 1);
        @(negedge clk);
        check("ovr_clear", int'(bus.overrun), 0);
        check("ovr_early_valid", int'(bus.out_valid), 0);
        @(negedge clk);
        check("ovr_out_valid", int'(bus.out_valid), 1);
        check("ovr_out_sample", int'($signed(bus.out_sample)), exp_a);
        hist.push_back(a);
        txn++;
        $display("txn %0d overrun in=%0d dropped=%0d out=%0d exp=%0d",
                 txn, a, b, int'($signed(bus.out_sample)), exp_a);
        xfer_model(rnd_s(), 1, "after_ovr");

        // Build history, then change del_ms while a sample is in READ.
        for (int i = 0; i < 30; i++) xfer_model(rnd_s(), 1, "rand_d1");
        s = rnd_s();
        xfer(s, 1, 2, model_out(s, 1), "delchg_old");
        for (int i = 0; i < 3; i++) xfer_model(rnd_s(), 2, "delchg_new");

        // Reset asserted while a sample is in READ.
        bus.in_valid  = 1'b1;
        bus.in_sample = 12'sd700;
        bus.del_ms    = 12'd0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        hist.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_reset_no_valid", int'(bus.out_valid), 0);
        end
        for (int i = 0; i < 10; i++) xfer_model(rnd_s(), 1, "post_reset");

        // Long run at 12000-sample delay, wrapping the write pointer.
        for (int i = 0; i < 16450; i++) xfer_model(rnd_s(), 1500, "d1500");
        // Clamped to the deepest tap.
        for (int i = 0; i < 30; i++) xfer_model(rnd_s(), 4095, "d4095");
        // Mixed delays.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(3) == 0) xfer_model(rnd_s(), int'($urandom_range(4095)), "rand_ms");
            else xfer_model(rnd_s(), msset[$urandom_range(6)], "set_ms");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
